// File: rtl/cache_request_credit_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_request_credit_scheduler_pkg
//  Description : Shared types and constants for the cache request credit
//                scheduler (FSM states, grant record, credit default).
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_request_credit_scheduler_pkg;

  // Default per-requester outstanding request budget
  localparam int CACHE_SCHED_MAX_CREDITS = 8;

  // Widest requester index (16 requesters)
  localparam int CACHE_SCHED_ID_MAX_W = 4;

  typedef enum logic [2:0] {
    S_SETUP = 3'd0,
    S_IDLE  = 3'd1,
    S_ARB   = 3'd2,
    S_STALL = 3'd3,
    S_DRAIN = 3'd4
  } SchedulerState;

  typedef struct packed {
    logic                            valid;
    logic [CACHE_SCHED_ID_MAX_W-1:0] id;
  } SchedulerGrant;

endpackage : cache_request_credit_scheduler_pkg
`default_nettype wire

// File: rtl/cache_request_credit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : cache_request_credit_counter
//  Description : One requester's credit counter. Resets full, decrements on
//                grant, increments on response, saturates at MAX_CREDITS.
//                full_o reflects the count after this cycle's update so the
//                scheduler can act on it in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_request_credit_counter #(
  parameter int MAX_CREDITS = 8,
  parameter int CREDIT_W    = $clog2(MAX_CREDITS + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic empty_o,
  output logic full_o,
  output logic overflow_o
);

  localparam logic [CREDIT_W-1:0] C_MAX = CREDIT_W'(MAX_CREDITS);

  logic [CREDIT_W-1:0] count_q;
  logic [CREDIT_W-1:0] count_d;

  // Next count: simultaneous inc and dec cancel; inc saturates, dec floors
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i) begin
      if (count_q != C_MAX) count_d = count_q + CREDIT_W'(1);
    end else if (dec_i && !inc_i) begin
      if (count_q != '0) count_d = count_q - CREDIT_W'(1);
    end
  end

  // Credit register, full budget out of reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= C_MAX;
    else       count_q <= count_d;
  end

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_d == C_MAX);
  assign overflow_o = inc_i && !dec_i && (count_q == C_MAX);

endmodule : cache_request_credit_counter
`default_nettype wire

// File: rtl/cache_request_credit_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : cache_request_credit_scheduler
//  Description : Credit-based round-robin scheduler deciding which memory
//                requester may push into the shared cache request FIFO.
//                Requests are registered once before arbitration, grants are
//                registered single-cycle pulses, and every grant consumes one
//                credit that returns with the matching cache response.
//  Option      : CACHE_SCHED_CREDIT_CHECK_EN enables the sticky
//                credit_error_out over-return / bad-id flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_request_credit_scheduler
  import cache_request_credit_scheduler_pkg::*;
#(
  parameter int NUM_MEMORY_REQUESTOR = 2,
  parameter int MAX_CREDITS          = CACHE_SCHED_MAX_CREDITS,
  parameter int ID_W                 = (NUM_MEMORY_REQUESTOR > 1) ? $clog2(NUM_MEMORY_REQUESTOR) : 1,
  parameter int CREDIT_W             = $clog2(MAX_CREDITS + 1)
) (
  input  logic                            ap_clk,
  input  logic                            areset,
  input  logic                            enable_in,
  input  logic [NUM_MEMORY_REQUESTOR-1:0] arbiter_request_in,
  input  logic                            fifo_setup_in,
  input  logic                            fifo_prog_full_in,
  input  logic                            response_valid_in,
  input  logic [ID_W-1:0]                 response_id_in,
  output logic [NUM_MEMORY_REQUESTOR-1:0] arbiter_grant_out,
  output logic                            grant_valid_out,
  output logic [ID_W-1:0]                 grant_id_out,
  output logic [NUM_MEMORY_REQUESTOR-1:0] credits_empty_out,
  output logic                            idle_out,
  output logic                            credit_error_out
);

  localparam int N = NUM_MEMORY_REQUESTOR;

  SchedulerState state_q;
  SchedulerState state_d;
  SchedulerGrant grant_q;

  logic [N-1:0]    req_q;
  logic [N-1:0]    grant_vec_q;
  logic [ID_W-1:0] rr_q;
  logic [ID_W-1:0] rr_d;
  logic            idle_q;

  logic [N-1:0]    w_inc;
  logic [N-1:0]    w_dec;
  logic [N-1:0]    w_empty;
  logic [N-1:0]    w_full_next;
  logic [N-1:0]    w_overflow;
  logic [N-1:0]    w_eligible;
  logic            w_all_full_next;
  logic            w_pick_valid;
  logic [ID_W-1:0] w_pick_id;
  logic            w_fire;

  // --------------------------------------------------------------------------
  // Per-requester credit counters
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N; i++) begin : g_credit
    // Out-of-range response ids match no counter and are dropped here
    assign w_inc[i] = response_valid_in && (response_id_in == ID_W'(i));
    assign w_dec[i] = w_fire && (w_pick_id == ID_W'(i));

    cache_request_credit_counter #(
      .MAX_CREDITS (MAX_CREDITS),
      .CREDIT_W    (CREDIT_W)
    ) u_counter (
      .clk_i      (ap_clk),
      .rst_i      (areset),
      .inc_i      (w_inc[i]),
      .dec_i      (w_dec[i]),
      .empty_o    (w_empty[i]),
      .full_o     (w_full_next[i]),
      .overflow_o (w_overflow[i])
    );
  end : g_credit

  assign w_all_full_next = &w_full_next;
  assign w_eligible      = req_q & ~w_empty;

  // --------------------------------------------------------------------------
  // Round-robin pick: first eligible index at or above rr_q, wrapping
  // --------------------------------------------------------------------------
  // Search eligible requesters starting from the round-robin pointer
  always_comb begin
    int idx;
    idx          = 0;
    w_pick_valid = 1'b0;
    w_pick_id    = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!w_pick_valid && w_eligible[idx[ID_W-1:0]]) begin
        w_pick_valid = 1'b1;
        w_pick_id    = idx[ID_W-1:0];
      end
    end
  end

  // A grant fires only in arbitration with no setup, stall or disable pending
  always_comb begin
    w_fire = (state_q == S_ARB) && !fifo_setup_in && !fifo_prog_full_in &&
             enable_in && w_pick_valid;
  end

  // Pointer moves just past the winner; it holds when nothing is granted
  always_comb begin
    int nxt;
    nxt  = 0;
    rr_d = rr_q;
    if (w_fire) begin
      nxt = int'(w_pick_id) + 1;
      if (nxt >= N) nxt = 0;
      rr_d = ID_W'(nxt);
    end
  end

  // --------------------------------------------------------------------------
  // Scheduler FSM next state (setup > prog_full > enable)
  // --------------------------------------------------------------------------
  // Drain exits on next-state credits so idle follows the last response
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SETUP: if (!fifo_setup_in) state_d = S_IDLE;
      S_IDLE:  if (enable_in) state_d = S_ARB;
      S_ARB: begin
        if (fifo_setup_in)          state_d = S_SETUP;
        else if (fifo_prog_full_in) state_d = S_STALL;
        else if (!enable_in)        state_d = S_DRAIN;
      end
      S_STALL: begin
        if (fifo_setup_in)          state_d = S_SETUP;
        else if (fifo_prog_full_in) state_d = S_STALL;
        else if (!enable_in)        state_d = S_DRAIN;
        else                        state_d = S_ARB;
      end
      S_DRAIN: begin
        if (enable_in)            state_d = S_ARB;
        else if (w_all_full_next) state_d = S_IDLE;
      end
      default: state_d = S_SETUP;
    endcase
  end

  // FSM state, request sample stage, pointer and registered outputs
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      state_q     <= S_SETUP;
      req_q       <= '0;
      rr_q        <= '0;
      grant_vec_q <= '0;
      grant_q     <= '0;
      idle_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_q         <= arbiter_request_in;
      rr_q          <= rr_d;
      grant_vec_q   <= w_dec;
      grant_q.valid <= w_fire;
      grant_q.id    <= w_fire ? CACHE_SCHED_ID_MAX_W'(w_pick_id) : '0;
      idle_q        <= (state_d == S_IDLE) && w_all_full_next &&
                       (arbiter_request_in == '0);
    end
  end

  assign arbiter_grant_out = grant_vec_q;
  assign grant_valid_out   = grant_q.valid;
  assign grant_id_out      = grant_q.id[ID_W-1:0];
  assign credits_empty_out = w_empty;
  assign idle_out          = idle_q;

  logic unused_grant_id;
  assign unused_grant_id = ^grant_q.id;

  // --------------------------------------------------------------------------
  // Optional credit accounting check
  // --------------------------------------------------------------------------
`ifdef CACHE_SCHED_CREDIT_CHECK_EN
  localparam int ID_SPACE = 1 << ID_W;

  logic [ID_SPACE-1:0] w_id_ok;
  logic                w_bad_resp;
  logic                err_q;

  for (genvar j = 0; j < ID_SPACE; j++) begin : g_id_ok
    assign w_id_ok[j] = (j < N);
  end : g_id_ok

  assign w_bad_resp = response_valid_in &&
                      (!w_id_ok[response_id_in] || |(w_overflow & w_inc));

  // Sticky error flag, cleared only by reset
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset)          err_q <= 1'b0;
    else if (w_bad_resp) err_q <= 1'b1;
  end

  assign credit_error_out = err_q;
`else
  logic unused_overflow;
  assign unused_overflow  = ^w_overflow;
  assign credit_error_out = 1'b0;
`endif

endmodule : cache_request_credit_scheduler
`default_nettype wire

// File: tb/tb_cache_request_credit_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_request_credit_scheduler
//  Description : Self-checking bench for cache_request_credit_scheduler with
//                directed scenarios and a randomized run against a
//                behavioural model of the scheduling rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_request_credit_scheduler;

  localparam int N    = 2;
  localparam int MAXC = 8;
  localparam int IDW  = 1;
`ifdef CACHE_SCHED_CREDIT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic           ap_clk = 1'b0;
  logic           areset = 1'b1;
  logic           enable_in = 1'b0;
  logic [N-1:0]   arbiter_request_in = '0;
  logic           fifo_setup_in = 1'b0;
  logic           fifo_prog_full_in = 1'b0;
  logic           response_valid_in = 1'b0;
  logic [IDW-1:0] response_id_in = '0;
  logic [N-1:0]   arbiter_grant_out;
  logic           grant_valid_out;
  logic [IDW-1:0] grant_id_out;
  logic [N-1:0]   credits_empty_out;
  logic           idle_out;
  logic           credit_error_out;

  int vectors = 0;
  int errors  = 0;

  always #5 ap_clk = ~ap_clk;

  cache_request_credit_scheduler #(
    .NUM_MEMORY_REQUESTOR (N),
    .MAX_CREDITS          (MAXC)
  ) dut (
    .ap_clk             (ap_clk),
    .areset             (areset),
    .enable_in          (enable_in),
    .arbiter_request_in (arbiter_request_in),
    .fifo_setup_in      (fifo_setup_in),
    .fifo_prog_full_in  (fifo_prog_full_in),
    .response_valid_in  (response_valid_in),
    .response_id_in     (response_id_in),
    .arbiter_grant_out  (arbiter_grant_out),
    .grant_valid_out    (grant_valid_out),
    .grant_id_out       (grant_id_out),
    .credits_empty_out  (credits_empty_out),
    .idle_out           (idle_out),
    .credit_error_out   (credit_error_out)
  );

  // --------------------------------------------------------------------------
  // Behavioural model: modes, credit budget per requester, rotating priority
  // --------------------------------------------------------------------------
  typedef enum int {M_SETUP, M_IDLE, M_ARB, M_STALL, M_DRAIN} mode_t;

  mode_t        m_mode;
  int           m_cred [N];
  int           m_rr;
  logic [N-1:0] m_seen;      // requests as seen one edge earlier
  logic [N-1:0] m_grant;
  int           m_gid;
  bit           m_idle;
  bit           m_err;

  task automatic model_reset();
    m_mode = M_SETUP;
    foreach (m_cred[i]) m_cred[i] = MAXC;
    m_rr    = 0;
    m_seen  = '0;
    m_grant = '0;
    m_gid   = 0;
    m_idle  = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_clock();
    mode_t nm;
    bit    fire;
    int    win;
    int    nc [N];
    bit    all_full;
    int    rid;
    nm   = m_mode;
    fire = 1'b0;
    win  = 0;
    foreach (nc[i]) nc[i] = m_cred[i];
    case (m_mode)
      M_SETUP: if (!fifo_setup_in) nm = M_IDLE;
      M_IDLE:  if (enable_in) nm = M_ARB;
      M_ARB, M_STALL: begin
        if (fifo_setup_in)          nm = M_SETUP;
        else if (fifo_prog_full_in) nm = M_STALL;
        else if (!enable_in)        nm = M_DRAIN;
        else if (m_mode == M_STALL) nm = M_ARB;
        else begin
          for (int k = 0; k < N; k++) begin
            int c;
            c = (m_rr + k) % N;
            if (!fire && m_seen[c] && m_cred[c] > 0) begin
              fire = 1'b1;
              win  = c;
            end
          end
        end
      end
      default: ;
    endcase
    if (fire) nc[win] = nc[win] - 1;
    if (response_valid_in) begin
      rid = int'(response_id_in);
      if (rid >= N)              m_err = m_err | CHK;
      else if (nc[rid] == MAXC)  m_err = m_err | CHK;
      else                       nc[rid] = nc[rid] + 1;
    end
    all_full = 1'b1;
    foreach (nc[i]) if (nc[i] != MAXC) all_full = 1'b0;
    if (m_mode == M_DRAIN) begin
      if (enable_in)     nm = M_ARB;
      else if (all_full) nm = M_IDLE;
    end
    m_grant = '0;
    if (fire) begin
      m_grant[win] = 1'b1;
      m_gid        = win;
      m_rr         = (win + 1) % N;
    end
    m_idle = (nm == M_IDLE) && all_full && (arbiter_request_in == '0);
    foreach (nc[i]) m_cred[i] = nc[i];
    m_seen = arbiter_request_in;
    m_mode = nm;
  endtask

  function automatic logic [N-1:0] model_empty();
    logic [N-1:0] e;
    e = '0;
    for (int i = 0; i < N; i++) e[i] = (m_cred[i] == 0);
    return e;
  endfunction

  // One clock: DUT and model both consume the current inputs at the edge
  task automatic step();
    @(posedge ap_clk);
    model_clock();
    #1;
  endtask

  task automatic do_reset();
    areset             = 1'b1;
    enable_in          = 1'b0;
    arbiter_request_in = '0;
    fifo_setup_in      = 1'b0;
    fifo_prog_full_in  = 1'b0;
    response_valid_in  = 1'b0;
    response_id_in     = '0;
    repeat (2) @(posedge ap_clk);
    #1;
    model_reset();
    areset = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    areset             = 1'b1;
    enable_in          = 1'b1;
    arbiter_request_in = '1;
    fifo_setup_in      = 1'b0;
    response_valid_in  = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    vectors++;
    if (arbiter_grant_out !== '0) begin errors++; $display("FAIL reset_grant got=%b want=0", arbiter_grant_out); end
    vectors++;
    if (grant_valid_out !== 1'b0) begin errors++; $display("FAIL reset_gvalid got=%b want=0", grant_valid_out); end
    vectors++;
    if (grant_id_out !== '0) begin errors++; $display("FAIL reset_gid got=%0d want=0", grant_id_out); end
    vectors++;
    if (credits_empty_out !== '0) begin errors++; $display("FAIL reset_empty got=%b want=0", credits_empty_out); end
    vectors++;
    if (idle_out !== 1'b0) begin errors++; $display("FAIL reset_idle got=%b want=0", idle_out); end
    vectors++;
    if (credit_error_out !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", credit_error_out); end
  endtask

  task automatic test_setup_hold();
    int  wait_cnt;
    bit  seen;
    do_reset();
    fifo_setup_in      = 1'b1;
    enable_in          = 1'b1;
    arbiter_request_in = 2'b11;
    for (int c = 0; c < 5; c++) begin
      step();
      vectors++;
      if (grant_valid_out !== 1'b0) begin errors++; $display("FAIL setup_nogrant cycle=%0d got=%b want=0", c, grant_valid_out); end
    end
    fifo_setup_in = 1'b0;
    seen = 1'b0;
    wait_cnt = 0;
    while (!seen && wait_cnt < 8) begin
      step();
      wait_cnt++;
      vectors++;
      if (grant_valid_out !== (m_grant != '0)) begin
        errors++; $display("FAIL setup_first_grant step=%0d got=%b want=%b", wait_cnt, grant_valid_out, (m_grant != '0));
      end
      seen = grant_valid_out || (m_grant != '0);
    end
    vectors++;
    if (!seen) begin errors++; $display("FAIL setup_grant_timeout got=none want=grant"); end
    vectors++;
    if (arbiter_grant_out !== 2'b01) begin errors++; $display("FAIL setup_first_id got=%b want=01", arbiter_grant_out); end
  endtask

  task automatic test_alternate();
    int ids[$];
    int cnt0, cnt1;
    do_reset();
    enable_in          = 1'b1;
    arbiter_request_in = 2'b11;
    for (int c = 0; c < 24; c++) begin
      step();
      if (grant_valid_out) ids.push_back(int'(grant_id_out));
    end
    cnt0 = 0; cnt1 = 0;
    foreach (ids[k]) begin
      if (ids[k] == 0) cnt0++; else cnt1++;
      vectors++;
      if (ids[k] != (k % 2)) begin errors++; $display("FAIL alt_order idx=%0d got=%0d want=%0d", k, ids[k], k % 2); end
    end
    vectors++;
    if (cnt0 != MAXC || cnt1 != MAXC) begin errors++; $display("FAIL alt_counts got=%0d/%0d want=%0d/%0d", cnt0, cnt1, MAXC, MAXC); end
    vectors++;
    if (credits_empty_out !== 2'b11) begin errors++; $display("FAIL alt_empty got=%b want=11", credits_empty_out); end
    vectors++;
    if (grant_valid_out !== 1'b0) begin errors++; $display("FAIL alt_stopped got=%b want=0", grant_valid_out); end
  endtask

  // Runs right after test_alternate with both budgets exhausted
  task automatic test_credit_return();
    response_valid_in = 1'b1;
    response_id_in    = 1'b0;
    step();
    vectors++;
    if (grant_valid_out !== 1'b0) begin errors++; $display("FAIL ret_blocked got=%b want=0", grant_valid_out); end
    response_valid_in = 1'b0;
    step();
    vectors++;
    if (arbiter_grant_out !== 2'b01) begin errors++; $display("FAIL ret_regrant0 got=%b want=01", arbiter_grant_out); end
    response_valid_in = 1'b1;
    response_id_in    = 1'b1;
    step();
    vectors++;
    if (grant_valid_out !== 1'b0) begin errors++; $display("FAIL ret_prime1 got=%b want=0", grant_valid_out); end
    step();
    vectors++;
    if (arbiter_grant_out !== 2'b10) begin errors++; $display("FAIL ret_same_cycle_grant got=%b want=10", arbiter_grant_out); end
    vectors++;
    if (credits_empty_out !== 2'b01) begin errors++; $display("FAIL ret_same_cycle_credit got=%b want=01", credits_empty_out); end
    response_valid_in = 1'b0;
    step();
    vectors++;
    if (arbiter_grant_out !== 2'b10) begin errors++; $display("FAIL ret_last1 got=%b want=10", arbiter_grant_out); end
    step();
    vectors++;
    if (credits_empty_out !== 2'b11 || grant_valid_out !== 1'b0) begin
      errors++; $display("FAIL ret_exhausted got=%b/%b want=11/0", credits_empty_out, grant_valid_out);
    end
  endtask

  task automatic run_until_grants(input int target);
    int got, cyc;
    got = 0; cyc = 0;
    while (got < target && cyc < 20) begin
      step();
      cyc++;
      if (grant_valid_out) got++;
    end
    vectors++;
    if (got != target) begin errors++; $display("FAIL grant_timeout got=%0d want=%0d", got, target); end
  endtask

  task automatic test_stall();
    int  cyc;
    bit  seen;
    do_reset();
    enable_in          = 1'b1;
    arbiter_request_in = 2'b11;
    run_until_grants(3);
    fifo_prog_full_in = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      vectors++;
      if (grant_valid_out !== 1'b0) begin errors++; $display("FAIL stall_nogrant cycle=%0d got=%b want=0", c, grant_valid_out); end
    end
    fifo_prog_full_in = 1'b0;
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 6) begin
      step();
      cyc++;
      seen = grant_valid_out;
    end
    vectors++;
    if (!seen || grant_id_out !== 1'b1) begin errors++; $display("FAIL stall_resume got=%b/%0d want=1/1", seen, grant_id_out); end
  endtask

  task automatic test_drain();
    int rids[3] = '{0, 1, 0};
    do_reset();
    enable_in          = 1'b1;
    arbiter_request_in = 2'b11;
    run_until_grants(3);
    enable_in          = 1'b0;
    arbiter_request_in = 2'b00;
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++;
      if (grant_valid_out !== 1'b0 || idle_out !== 1'b0) begin
        errors++; $display("FAIL drain_hold cycle=%0d got=%b/%b want=0/0", c, grant_valid_out, idle_out);
      end
    end
    for (int r = 0; r < 3; r++) begin
      response_valid_in = 1'b1;
      response_id_in    = rids[r][IDW-1:0];
      step();
      response_valid_in = 1'b0;
      vectors++;
      if (idle_out !== (r == 2)) begin errors++; $display("FAIL drain_idle resp=%0d got=%b want=%b", r, idle_out, (r == 2)); end
      step();
      vectors++;
      if (idle_out !== (r == 2)) begin errors++; $display("FAIL drain_idle_gap resp=%0d got=%b want=%b", r, idle_out, (r == 2)); end
    end
  endtask

  task automatic test_credit_error();
    int got;
    do_reset();
    response_valid_in = 1'b1;
    response_id_in    = 1'b0;
    step();
    response_valid_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++;
      if (credit_error_out !== CHK) begin errors++; $display("FAIL err_sticky cycle=%0d got=%b want=%b", c, credit_error_out, CHK); end
    end
    enable_in          = 1'b1;
    arbiter_request_in = 2'b01;
    got = 0;
    for (int c = 0; c < 16; c++) begin
      step();
      if (grant_valid_out) got++;
    end
    vectors++;
    if (got != MAXC) begin errors++; $display("FAIL err_saturate got=%0d want=%0d", got, MAXC); end
    do_reset();
    step();
    vectors++;
    if (credit_error_out !== 1'b0) begin errors++; $display("FAIL err_cleared got=%b want=0", credit_error_out); end
  endtask

  task automatic test_random();
    logic [N-1:0] exp_empty;
    do_reset();
    enable_in = 1'b1;
    for (int c = 0; c < 600; c++) begin
      int rid;
      arbiter_request_in = N'($urandom);
      fifo_prog_full_in  = ($urandom % 8) == 0;
      fifo_setup_in      = ($urandom % 60) == 0;
      if (($urandom % 20) == 0) enable_in = ~enable_in;
      rid = int'($urandom % N);
      response_valid_in = ($urandom % 3) == 0;
      if (m_cred[rid] == MAXC && ($urandom % 20) != 0) response_valid_in = 1'b0;
      response_id_in = rid[IDW-1:0];
      step();
      exp_empty = model_empty();
      vectors++;
      if ({arbiter_grant_out, grant_valid_out, credits_empty_out, idle_out, credit_error_out} !==
          {m_grant, (m_grant != '0), exp_empty, m_idle, m_err}) begin
        errors++;
        $display("FAIL rand_outputs cycle=%0d got g=%b v=%b e=%b i=%b x=%b want g=%b v=%b e=%b i=%b x=%b",
                 c, arbiter_grant_out, grant_valid_out, credits_empty_out, idle_out, credit_error_out,
                 m_grant, (m_grant != '0), exp_empty, m_idle, m_err);
      end
      if (m_grant != '0) begin
        vectors++;
        if (int'(grant_id_out) != m_gid) begin errors++; $display("FAIL rand_gid cycle=%0d got=%0d want=%0d", c, grant_id_out, m_gid); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_setup_hold();
    test_alternate();
    test_credit_return();
    test_stall();
    test_drain();
    test_credit_error();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_cache_request_credit_scheduler
`default_nettype wire

// File: doc/cache_request_credit_scheduler.md
Name: cache_request_credit_scheduler

Overview:
- Credit-based round-robin scheduler in front of the cache request generator.
- Decides which memory requester may push a MemoryPacket into the shared cache request FIFO.
- Caps outstanding cache requests per requester; credits return on cache responses.
- Stalls all grants while the downstream FIFO is in reset or prog_full.

Parameters:
NUM_MEMORY_REQUESTOR, 2, number of requesters (1..16)
MAX_CREDITS, 8, max outstanding requests per requester (1..255)
ID_W, max(1,$clog2(NUM_MEMORY_REQUESTOR)), requester index width
CREDIT_W, $clog2(MAX_CREDITS+1), per-requester credit counter width

Ports:
ap_clk  in  1  clock
areset  in  1  asynchronous, active-high reset
enable_in  in  1  kernel descriptor valid; scheduling allowed
arbiter_request_in  in  NUM_MEMORY_REQUESTOR  per-requester request level
fifo_setup_in  in  1  downstream FIFO wr/rd reset busy
fifo_prog_full_in  in  1  downstream FIFO prog_full
response_valid_in  in  1  one cache response returned this cycle
response_id_in  in  ID_W  requester owning the returned response
arbiter_grant_out  out  NUM_MEMORY_REQUESTOR  one-hot grant pulse, registered
grant_valid_out  out  1  OR of arbiter_grant_out
grant_id_out  out  ID_W  index of granted requester
credits_empty_out  out  NUM_MEMORY_REQUESTOR  bit i high when credit[i]==0
idle_out  out  1  state S_IDLE, all credits full, no requests
credit_error_out  out  1  sticky credit over-return flag (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): state S_SETUP; credit[i]=MAX_CREDITS; rr_ptr=0.
- Outputs during reset: grants 0, grant_valid_out 0, grant_id_out 0, credits_empty_out 0, idle_out 0, credit_error_out 0.
- Reset mid-operation discards all outstanding accounting. In-flight responses arriving after release are treated as over-returns.
- FSM:
  - S_SETUP: stay while fifo_setup_in=1; otherwise go to S_IDLE.
  - S_IDLE: enable_in=1 -> S_ARB.
  - S_ARB: each cycle, eligible = arbiter_request_in & ~credits_empty.
    - Winner = first eligible index searching upward, with wrap, from rr_ptr.
    - Next edge: arbiter_grant_out = onehot(winner); rr_ptr = winner+1 mod N; credit[winner] decrements.
    - No eligible requester -> no grant, rr_ptr holds.
    - fifo_prog_full_in=1 -> S_STALL; no grant issued that edge.
    - fifo_setup_in=1 -> S_SETUP.
    - enable_in=0 -> S_DRAIN.
    - Priority: setup > prog_full > enable.
  - S_STALL: return to S_ARB when prog_full=0. Setup and enable checks as in S_ARB.
  - S_DRAIN: no grants. -> S_IDLE when all credits == MAX_CREDITS. enable_in=1 -> S_ARB.
- Grant latency: request sampled at edge k, grant visible after edge k+1. At most one grant per cycle.
- Grant is a single-cycle pulse. A requester holding request high is re-granted only per round-robin order.
- Credits:
  - Response in any state increments credit[response_id_in].
  - Same-cycle grant and response for the same index: net unchanged.
  - Increment at MAX_CREDITS saturates (no wrap). Decrement never occurs at 0 (ineligible).
  - response_id_in >= NUM_MEMORY_REQUESTOR is ignored.
- credits_empty_out and idle_out are registered from next-state values, so they are consistent with the grant in the same cycle.
- N=1 degenerates to a credit gate; rr_ptr is constant 0.

Optional Feature:
- Macro CACHE_SCHED_CREDIT_CHECK_EN.
- Defined: credit_error_out sets on a response that would exceed MAX_CREDITS, or on an out-of-range response_id_in. Sticky until areset.
- Undefined: credit_error_out tied 0; saturation and ignore behaviour unchanged; no check logic synthesized.

Decomposition:
- Shared package:
  - SchedulerState enum (S_SETUP, S_IDLE, S_ARB, S_STALL, S_DRAIN).
  - CACHE_SCHED_MAX_CREDITS default constant.
  - SchedulerGrant struct {valid, id}.
- Sub-module cache_request_credit_counter: one credit counter with inc/dec/saturate, empty, full and overflow outputs. Instantiated NUM_MEMORY_REQUESTOR times.
- Round-robin pick is in-module combinational logic.

Test Plan:
- Reset release, fifo_setup_in high 5 cycles, enable_in=1 -> no grant until setup drops. First grant arrives 2 edges after S_ARB entry.
- N=2, MAX_CREDITS=8, both requesting continuously, no responses -> grants alternate 0,1,0,1… Exactly 8 each, then credits_empty_out=2'b11, grants stop.
- Requester 0 at credit 0, response id 0 same cycle it is eligible-blocked -> granted next cycle. Grant and response same cycle on id 1 -> credit[1] unchanged.
- fifo_prog_full_in asserted mid-stream for 4 cycles -> zero grants during stall; resume with rr_ptr preserved.
- enable_in dropped with 3 outstanding -> S_DRAIN, no grants. idle_out rises the cycle after the 3rd response.
- With CACHE_SCHED_CREDIT_CHECK_EN: response to a full-credit requester -> credit stays 8, credit_error_out=1 until areset. Without the macro -> flag stays 0.
